// File: rtl/riscv_decode_ctrl_pipe_if.sv
// Handshake and decoded-payload bundle between fetch, the decode stage and execute.
// The stage itself attaches through the slave modport; whoever feeds it uses master.
interface riscv_decode_ctrl_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        alu_control;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              branch;
    logic              alusrc;
    logic [XLEN-1:0]   imm;
    logic              illegal;
    logic [CNT_W-1:0]  illegal_cnt;
    logic              cnt_clr;

    modport master (
        output in_valid, instr, out_ready, cnt_clr,
        input  in_ready, out_valid, alu_control, regwrite, memread, memwrite,
               branch, alusrc, imm, illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, instr, out_ready, cnt_clr,
        output in_ready, out_valid, alu_control, regwrite, memread, memwrite,
               branch, alusrc, imm, illegal, illegal_cnt
    );
endinterface

// File: rtl/riscv_decode_ctrl_pipe.sv
// Registered RV32I/RV64I main decoder and ALU control behind a single valid/ready stage.
// Illegal encodings produce a zeroed payload with the illegal flag and bump a saturating counter.
module riscv_decode_ctrl_pipe #(
    parameter int XLEN       = 32,
    parameter bit ENABLE_MUL = 1'b1,
    parameter int CNT_W      = 8
) (
    input  logic wb_clk_i,
    input  logic wb_rst_n,
    riscv_decode_ctrl_pipe_if.slave bus
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_MUL  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    typedef struct packed {
        logic            illegal;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            branch;
        logic            alusrc;
        logic [3:0]      alu;
        logic [XLEN-1:0] imm;
    } payload_t;

    payload_t         dec;
    payload_t         pay_d, pay_q;
    logic             out_valid_d, out_valid_q;
    logic [CNT_W-1:0] illegal_cnt_d, illegal_cnt_q;
    logic             accept;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             shift_hi_zero;
    logic             shift_hi_sra;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];

    // RV64 shift immediates carry a 6-bit shamt, so only instr[31:26] qualifies the shift kind.
    assign shift_hi_zero = (XLEN == 64) ? (bus.instr[31:26] == 6'b000000)
                                        : (bus.instr[31:25] == 7'b0000000);
    assign shift_hi_sra  = (XLEN == 64) ? (bus.instr[31:26] == 6'b010000)
                                        : (bus.instr[31:25] == 7'b0100000);

    assign imm_i = XLEN'($signed(bus.instr[31:20]));
    assign imm_s = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
    assign imm_b = XLEN'($signed({bus.instr[31], bus.instr[7], bus.instr[30:25],
                                  bus.instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({bus.instr[31:12], 12'b0}));

    always_comb begin
        dec = '0;
        dec.alu = ALU_ADD;
        case (opcode)
            OP_R: begin
                dec.regwrite = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec.alu = ALU_ADD;
                    {7'b0100000, 3'b000}: dec.alu = ALU_SUB;
                    {7'b0000000, 3'b001}: dec.alu = ALU_SLL;
                    {7'b0000000, 3'b010}: dec.alu = ALU_SLT;
                    {7'b0000000, 3'b011}: dec.alu = ALU_SLTU;
                    {7'b0000000, 3'b100}: dec.alu = ALU_XOR;
                    {7'b0000000, 3'b101}: dec.alu = ALU_SRL;
                    {7'b0100000, 3'b101}: dec.alu = ALU_SRA;
                    {7'b0000000, 3'b110}: dec.alu = ALU_OR;
                    {7'b0000000, 3'b111}: dec.alu = ALU_AND;
                    {7'b0000001, 3'b000}: begin
                        dec.alu     = ALU_MUL;
                        dec.illegal = !ENABLE_MUL;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_IALU: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.imm      = imm_i;
                case (funct3)
                    3'b000: dec.alu = ALU_ADD;
                    3'b010: dec.alu = ALU_SLT;
                    3'b011: dec.alu = ALU_SLTU;
                    3'b100: dec.alu = ALU_XOR;
                    3'b110: dec.alu = ALU_OR;
                    3'b111: dec.alu = ALU_AND;
                    3'b001: begin
                        dec.alu     = ALU_SLL;
                        dec.illegal = !shift_hi_zero;
                    end
                    default: begin
                        dec.alu     = shift_hi_sra ? ALU_SRA : ALU_SRL;
                        dec.illegal = !(shift_hi_zero || shift_hi_sra);
                    end
                endcase
            end
            OP_LOAD: begin
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.alusrc   = 1'b1;
                dec.imm      = imm_i;
            end
            OP_STORE: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.imm      = imm_s;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.alu    = ALU_SUB;
                dec.imm    = imm_b;
            end
            OP_LUI: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.imm      = imm_u;
            end
            default: dec.illegal = 1'b1;
        endcase
        // An illegal word must never leak partial controls into execute.
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            dec.alu     = ALU_AND;
        end
    end

    always_comb begin
        pay_d       = pay_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            pay_d       = dec;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        illegal_cnt_d = illegal_cnt_q;
        if (bus.cnt_clr) begin
            illegal_cnt_d = '0;
        end else if (accept && dec.illegal && !(&illegal_cnt_q)) begin
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            pay_q         <= '0;
            out_valid_q   <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            pay_q         <= pay_d;
            out_valid_q   <= out_valid_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.alu_control = pay_q.alu;
    assign bus.regwrite    = pay_q.regwrite;
    assign bus.memread     = pay_q.memread;
    assign bus.memwrite    = pay_q.memwrite;
    assign bus.branch      = pay_q.branch;
    assign bus.alusrc      = pay_q.alusrc;
    assign bus.imm         = pay_q.imm;
    assign bus.illegal     = pay_q.illegal;
    assign bus.illegal_cnt = illegal_cnt_q;

    // Payload ALU field must be one of the defined codes.
    ERR_ALU_CODE: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n)
                                   pay_q.alu <= ALU_SLTU);

endmodule

// File: tb/tb_riscv_decode_ctrl_pipe.sv
// Drives two decoder configurations (RV32 with MUL, 8-bit counter / RV64 without MUL, 2-bit counter)
// with identical traffic and compares them against a mnemonic-level decode model.
module tb_riscv_decode_ctrl_pipe;

    logic wb_clk_i = 1'b0;
    logic wb_rst_n = 1'b0;

    always #5 wb_clk_i = ~wb_clk_i;

    riscv_decode_ctrl_pipe_if #(.XLEN(32), .CNT_W(8)) bus_a ();
    riscv_decode_ctrl_pipe_if #(.XLEN(64), .CNT_W(2)) bus_b ();

    riscv_decode_ctrl_pipe #(.XLEN(32), .ENABLE_MUL(1'b1), .CNT_W(8)) dut_a (
        .wb_clk_i (wb_clk_i),
        .wb_rst_n (wb_rst_n),
        .bus      (bus_a)
    );

    riscv_decode_ctrl_pipe #(.XLEN(64), .ENABLE_MUL(1'b0), .CNT_W(2)) dut_b (
        .wb_clk_i (wb_clk_i),
        .wb_rst_n (wb_rst_n),
        .bus      (bus_b)
    );

    typedef struct packed {
        bit        illegal;
        bit        regwrite;
        bit        memread;
        bit        memwrite;
        bit        branch;
        bit        alusrc;
        bit [3:0]  alu;
        bit [63:0] imm;
    } dec_t;

    int   errors = 0;
    int   checks = 0;
    bit   exp_valid;
    dec_t exp_a, exp_b;
    int   exp_cnt_a, exp_cnt_b;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_ADDI  = 32'hFFF00093;
    localparam logic [31:0] I_STORE = 32'hFE112E23;
    localparam logic [31:0] I_BEQ   = 32'hFE000EE3;
    localparam logic [31:0] I_SRAI  = 32'h4010D093;
    localparam logic [31:0] I_MUL   = 32'h022081B3;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    // Reference decode: pick a mnemonic from the opcode/funct rules, then look up its code.
    function automatic dec_t model_decode(input logic [31:0] w, input bit rv64, input bit mul_en);
        string  base[8]   = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
        string  codes[11] = '{"AND", "OR", "ADD", "SLL", "SUB", "SRL", "MUL", "XOR", "SRA", "SLT", "SLTU"};
        dec_t   d      = '0;
        string  op     = "";
        longint v      = 0;
        int     f3     = int'(w[14:12]);
        int     f7     = int'(w[31:25]);
        int     hi     = rv64 ? int'(w[31:26]) : int'(w[31:25]);
        int     sra_hi = rv64 ? 16 : 32;
        case (w[6:0])
            7'h33: begin
                d.regwrite = 1;
                if (f7 == 0) op = base[f3];
                else if (f7 == 32 && f3 == 0) op = "SUB";
                else if (f7 == 32 && f3 == 5) op = "SRA";
                else if (f7 == 1 && f3 == 0 && mul_en) op = "MUL";
            end
            7'h13: begin
                d.regwrite = 1;
                d.alusrc   = 1;
                v = w[31:20];
                if (v >= 2048) v -= 4096;
                if (f3 == 1) op = (hi == 0) ? "SLL" : "";
                else if (f3 == 5) op = (hi == 0) ? "SRL" : ((hi == sra_hi) ? "SRA" : "");
                else op = base[f3];
            end
            7'h03: begin
                op = "ADD";
                d.regwrite = 1;
                d.memread  = 1;
                d.alusrc   = 1;
                v = w[31:20];
                if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                op = "ADD";
                d.memwrite = 1;
                d.alusrc   = 1;
                v = {w[31:25], w[11:7]};
                if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                op = "SUB";
                d.branch = 1;
                v = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                if (v >= 4096) v -= 8192;
            end
            7'h37: begin
                op = "ADD";
                d.regwrite = 1;
                d.alusrc   = 1;
                v = w[31:12];
                v = v * 4096;
                if (w[31]) v -= 64'h1_0000_0000;
            end
            default: op = "";
        endcase
        if (op == "") begin
            d = '0;
            d.illegal = 1;
            return d;
        end
        for (int i = 0; i < 11; i++) if (codes[i] == op) d.alu = 4'(i);
        d.imm = 64'(v);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] imm_a_exp;
        imm_a_exp = exp_a.imm[31:0];
        chk({tag, "_a_valid"},  64'(bus_a.out_valid),   64'(exp_valid));
        chk({tag, "_b_valid"},  64'(bus_b.out_valid),   64'(exp_valid));
        chk({tag, "_a_alu"},    64'(bus_a.alu_control), 64'(exp_a.alu));
        chk({tag, "_b_alu"},    64'(bus_b.alu_control), 64'(exp_b.alu));
        chk({tag, "_a_ctl"},    64'({bus_a.illegal, bus_a.regwrite, bus_a.memread, bus_a.memwrite, bus_a.branch, bus_a.alusrc}),
                                64'({exp_a.illegal, exp_a.regwrite, exp_a.memread, exp_a.memwrite, exp_a.branch, exp_a.alusrc}));
        chk({tag, "_b_ctl"},    64'({bus_b.illegal, bus_b.regwrite, bus_b.memread, bus_b.memwrite, bus_b.branch, bus_b.alusrc}),
                                64'({exp_b.illegal, exp_b.regwrite, exp_b.memread, exp_b.memwrite, exp_b.branch, exp_b.alusrc}));
        chk({tag, "_a_imm"},    64'(bus_a.imm),         64'(imm_a_exp));
        chk({tag, "_b_imm"},    bus_b.imm,              exp_b.imm);
        chk({tag, "_a_cnt"},    64'(bus_a.illegal_cnt), 64'(exp_cnt_a));
        chk({tag, "_b_cnt"},    64'(bus_b.illegal_cnt), 64'(exp_cnt_b));
    endtask

    // One clock of traffic: drive, check in_ready, advance the model, then check registered outputs.
    task automatic applyStimulus(input bit v, input logic [31:0] w, input bit rdy, input bit clr,
                                 input string tag);
        bit   exp_ready;
        bit   acc;
        dec_t da, db;
        bus_a.in_valid = v;  bus_a.instr = w;  bus_a.out_ready = rdy;  bus_a.cnt_clr = clr;
        bus_b.in_valid = v;  bus_b.instr = w;  bus_b.out_ready = rdy;  bus_b.cnt_clr = clr;
        #1;
        exp_ready = !exp_valid || rdy;
        chk({tag, "_a_in_ready"}, 64'(bus_a.in_ready), 64'(exp_ready));
        chk({tag, "_b_in_ready"}, 64'(bus_b.in_ready), 64'(exp_ready));
        acc = v && exp_ready;
        da  = model_decode(w, 1'b0, 1'b1);
        db  = model_decode(w, 1'b1, 1'b0);
        if (acc) begin
            exp_a     = da;
            exp_b     = db;
            exp_valid = 1;
        end else if (rdy) begin
            exp_valid = 0;
        end
        if (clr) begin
            exp_cnt_a = 0;
            exp_cnt_b = 0;
        end else begin
            if (acc && da.illegal && exp_cnt_a < 255) exp_cnt_a++;
            if (acc && db.illegal && exp_cnt_b < 3)   exp_cnt_b++;
        end
        @(posedge wb_clk_i);
        #1;
        checkOutput(tag);
    endtask

    task automatic modelReset();
        exp_valid = 0;
        exp_a     = '0;
        exp_b     = '0;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        logic [6:0]  ops[7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h33};
        logic [6:0]  f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h00};
        int sel;
        w   = $urandom;
        sel = int'($urandom_range(0, 8));
        if (sel < 7) w[6:0] = ops[sel];
        if ($urandom_range(0, 3) != 0) begin
            w[31:25] = f7s[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1) w[25] = 1'b0;
        end
        return w;
    endfunction

    initial begin
        bus_a.in_valid = 0;  bus_a.instr = '0;  bus_a.out_ready = 0;  bus_a.cnt_clr = 0;
        bus_b.in_valid = 0;  bus_b.instr = '0;  bus_b.out_ready = 0;  bus_b.cnt_clr = 0;
        modelReset();
        #2;
        checkOutput("reset");
        #10;
        wb_rst_n = 1'b1;
        @(posedge wb_clk_i);
        #1;

        applyStimulus(1, I_ADD, 1, 0, "add");
        chk("add_alu_const", 64'(bus_a.alu_control), 64'h2);

        applyStimulus(1, I_ADDI, 1, 0, "addi");
        chk("addi_imm_const", 64'(bus_a.imm), 64'hFFFF_FFFF);
        applyStimulus(1, I_STORE, 1, 0, "store");
        chk("store_imm_const", 64'(bus_a.imm), 64'hFFFF_FFFC);

        applyStimulus(1, I_BEQ, 1, 0, "beq");
        chk("beq_imm_const", bus_b.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(1, I_SRAI, 1, 0, "srai");
        chk("srai_alu_const", 64'(bus_a.alu_control), 64'h8);

        applyStimulus(1, I_ADD, 1, 0, "bp_add");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, I_SUB, 0, 0, "bp_hold");
            chk("bp_hold_alu_const", 64'(bus_a.alu_control), 64'h2);
        end
        applyStimulus(1, I_SUB, 1, 0, "bp_release");
        chk("bp_sub_alu_const", 64'(bus_a.alu_control), 64'h4);
        applyStimulus(0, I_ADD, 1, 0, "drain");

        applyStimulus(1, I_MUL, 1, 0, "mul");
        chk("mul_a_alu_const", 64'(bus_a.alu_control), 64'h6);
        chk("mul_b_cnt_const", 64'(bus_b.illegal_cnt), 64'h1);

        for (int i = 0; i < 5; i++) applyStimulus(1, I_BAD, 1, 0, "bad");
        chk("sat_b_cnt_const", 64'(bus_b.illegal_cnt), 64'h3);
        applyStimulus(1, I_BAD, 1, 1, "clr_wins");
        chk("clr_b_cnt_const", 64'(bus_b.illegal_cnt), 64'h0);

        applyStimulus(1, I_ADD, 1, 0, "pre_hold");
        applyStimulus(1, I_SUB, 0, 0, "hold");
        wb_rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset");
        #2;
        wb_rst_n = 1'b1;
        @(posedge wb_clk_i);
        #1;

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, randInstr(), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0, "rand");
        end
        applyStimulus(0, '0, 1, 0, "final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
